e203_dtcm_ram_ctrl: RTL and testbench
=====================================

Name: e203_dtcm_ram_ctrl

Overview:
- ICB-to-SRAM controller directly upstream of the DTCM RAM wrapper; produces its sd/ds/ls/cs/we/addr/wem/din and consumes its 1-cycle-latency dout.
- Accepts one word-sized ICB command per cycle, returns one response per command in order, and holds read data across response back-pressure.
- Also sequences RAM low-power modes: light sleep after idle, deep sleep and shutdown on request.

Parameters:
- AW, 14, RAM word-address width (byte address width = AW+2).
- DW, 32, data width.
- MW, 4, byte-mask width (DW/8).
- IDLE_LS_CYC, 8, idle cycles before entering light sleep; 0 disables light sleep.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command ready
- icb_cmd_addr  in  AW+2  byte address
- icb_cmd_read  in  1  1=read, 0=write
- icb_cmd_wdata  in  DW  write data
- icb_cmd_wmask  in  MW  byte write enables
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response ready
- icb_rsp_rdata  out  DW  read data (0 for writes/errors)
- icb_rsp_err  out  1  misaligned-access error
- pwr_ds_req  in  1  deep-sleep request
- pwr_sd_req  in  1  shutdown request
- ram_sd / ram_ds / ram_ls  out  1 each  RAM power controls
- ram_cs  out  1  chip select
- ram_we  out  1  write enable
- ram_addr  out  AW  word address
- ram_wem  out  MW  byte write mask
- ram_din  out  DW  write data
- ram_dout  in  DW  RAM read data, valid the cycle after a read cs
- ctrl_idle  out  1  high when ACTIVE with no outstanding response

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - state=ACTIVE; idle counter=0; rsp_valid=0; rsp_err=0; hold register=0.
  - ram_ls/ds/sd=0.
  - icb_cmd_ready forced 0 while rst_n=0, so ram_cs=0.
  - Reset mid-transaction drops any pending response.
- Handshake:
  - Accept when cmd_valid && cmd_ready.
  - cmd_ready = (state==ACTIVE) && (!rsp_valid || rsp_ready).
  - At most one response outstanding; with rsp_ready held high, throughput is 1 command/cycle.
- RAM drive (combinational, accept cycle):
  - ram_cs = accept && addr[1:0]==0.
  - ram_we = ram_cs && !read.
  - ram_addr = addr[AW+1:2].
  - ram_wem = wmask when writing, else 0.
  - ram_din = wdata.
- Response:
  - rsp_valid rises the cycle after accept; stays high until rsp_ready.
  - Read: rdata = ram_dout in the first response cycle; captured into the hold register that cycle and presented from it thereafter.
  - Write: rdata = 0.
  - Misaligned (addr[1:0]!=0): no RAM access; err=1; rdata=0.
- State machine (ram_ls/ds/sd registered from state):
  - ACTIVE -> SD: pwr_sd_req && !rsp_valid.
  - ACTIVE -> DS: pwr_ds_req && !rsp_valid.
  - ACTIVE -> LS: idle counter == IDLE_LS_CYC (nonzero).
  - Priority sd > ds > ls.
  - Idle counter:
    - Increments in ACTIVE when !cmd_valid && !rsp_valid; saturates at IDLE_LS_CYC.
    - Clears on any cmd_valid or outstanding response, and on leaving ACTIVE.
  - LS -> WAKE: cmd_valid. LS -> DS/SD: request (same priority).
  - DS -> WAKE when pwr_ds_req=0 and pwr_sd_req=0; DS -> SD: pwr_sd_req.
  - SD -> WAKE when pwr_sd_req=0. If pwr_ds_req is still 1 when leaving SD, go SD -> DS instead.
  - WAKE lasts exactly 1 cycle with ls/ds/sd=0 and cmd_ready=0, then -> ACTIVE.
  - A command arriving in LS therefore waits 2 cycles: LS -> WAKE -> ACTIVE accept.
- Power outputs:
  - ram_ls=1 only in LS; ram_ds=1 only in DS; ram_sd=1 only in SD.
  - ram_cs is never 1 in LS/DS/SD/WAKE.
- ctrl_idle = (state==ACTIVE) && !rsp_valid.

Test Plan:
- Reset then write 0xDEADBEEF, mask 0xF, addr 0x0010, rsp_ready=1 -> ram_cs=1, we=1, ram_addr=0x004, wem=0xF in the accept cycle; rsp_valid next cycle, err=0, rdata=0.
- Read addr 0x0010 with RAM model returning 0xDEADBEEF; hold rsp_ready=0 for 3 cycles -> cmd_ready=0, rdata stays 0xDEADBEEF all 4 cycles; accept on the 4th.
- Back-to-back reads to 0x0,0x4,0x8 with rsp_ready=1 -> one accept per cycle; responses in order with matching data.
- Read addr 0x0013 -> ram_cs=0, rsp err=1, rdata=0.
- No traffic for 8 cycles -> ram_ls=1; then cmd_valid -> ls=0 next cycle (WAKE), accept the cycle after.
- Assert pwr_sd_req and pwr_ds_req with a response pending -> transition waits for rsp accept; then ram_sd=1. Drop sd with ds held -> ram_ds=1. Drop ds -> WAKE, then ACTIVE. Apply rst_n=0 mid-response -> rsp_valid=0 on the next cycle.

Source files
------------

// File: rtl/e203_dtcm_ram_ctrl.sv
// ICB-to-SRAM controller for the DTCM: one word command per cycle, in-order responses
// with read-data holding under back-pressure, and RAM light-sleep/deep-sleep/shutdown sequencing.
module e203_dtcm_ram_ctrl #(
  parameter int AW          = 14,
  parameter int DW          = 32,
  parameter int MW          = 4,
  parameter int IDLE_LS_CYC = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          icb_cmd_valid,
  output logic          icb_cmd_ready,
  input  logic [AW+1:0] icb_cmd_addr,
  input  logic          icb_cmd_read,
  input  logic [DW-1:0] icb_cmd_wdata,
  input  logic [MW-1:0] icb_cmd_wmask,
  output logic          icb_rsp_valid,
  input  logic          icb_rsp_ready,
  output logic [DW-1:0] icb_rsp_rdata,
  output logic          icb_rsp_err,
  input  logic          pwr_ds_req,
  input  logic          pwr_sd_req,
  output logic          ram_sd,
  output logic          ram_ds,
  output logic          ram_ls,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ctrl_idle
);

  typedef enum logic [2:0] {
    ST_ACTIVE,
    ST_LS,
    ST_DS,
    ST_SD,
    ST_WAKE
  } state_t;

  localparam int CW = (IDLE_LS_CYC < 1) ? 1 : $clog2(IDLE_LS_CYC + 1);
  localparam logic [CW-1:0] LS_LIM = CW'(IDLE_LS_CYC);

  state_t          state, state_next;
  logic [CW-1:0]   idle_cnt;
  logic            accept;
  logic            aligned;
  logic            rsp_rd;
  logic            rsp_first;
  logic [DW-1:0]   hold;
  logic            ls_hit;

  assign aligned = (icb_cmd_addr[1:0] == 2'b00);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_ACTIVE;
      ram_ls <= 1'b0;
      ram_ds <= 1'b0;
      ram_sd <= 1'b0;
    end else begin
      state  <= state_next;
      ram_ls <= (state_next == ST_LS);
      ram_ds <= (state_next == ST_DS);
      ram_sd <= (state_next == ST_SD);
    end
  end

  // A command in flight or arriving blocks light sleep even at the idle limit.
  assign ls_hit = (IDLE_LS_CYC != 0) && (idle_cnt == LS_LIM) &&
                  !icb_cmd_valid && !icb_rsp_valid;

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_ACTIVE: begin
        if (pwr_sd_req && !icb_rsp_valid && !accept)      state_next = ST_SD;
        else if (pwr_ds_req && !icb_rsp_valid && !accept) state_next = ST_DS;
        else if (ls_hit)                                  state_next = ST_LS;
      end
      ST_LS: begin
        if (pwr_sd_req)         state_next = ST_SD;
        else if (pwr_ds_req)    state_next = ST_DS;
        else if (icb_cmd_valid) state_next = ST_WAKE;
      end
      ST_DS: begin
        if (pwr_sd_req)      state_next = ST_SD;
        else if (!pwr_ds_req) state_next = ST_WAKE;
      end
      ST_SD: begin
        if (!pwr_sd_req) state_next = pwr_ds_req ? ST_DS : ST_WAKE;
      end
      ST_WAKE:   state_next = ST_ACTIVE;
      default:   state_next = ST_ACTIVE;
    endcase
  end

  always_comb begin
    icb_cmd_ready = rst_n && (state == ST_ACTIVE) && (!icb_rsp_valid || icb_rsp_ready);
    accept        = icb_cmd_valid && icb_cmd_ready;
    ram_cs        = accept && aligned;
    ram_we        = ram_cs && !icb_cmd_read;
    ram_addr      = icb_cmd_addr[AW+1:2];
    ram_wem       = ram_we ? icb_cmd_wmask : '0;
    ram_din       = icb_cmd_wdata;
    ctrl_idle     = (state == ST_ACTIVE) && !icb_rsp_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state != ST_ACTIVE || state_next != ST_ACTIVE ||
                 icb_cmd_valid || icb_rsp_valid) begin
      idle_cnt <= '0;
    end else if (idle_cnt != LS_LIM) begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end

  // Read data comes straight from the RAM in the first response cycle and from
  // the hold register afterwards, since ram_dout is only valid for that one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      icb_rsp_valid <= 1'b0;
      icb_rsp_err   <= 1'b0;
      rsp_rd        <= 1'b0;
      rsp_first     <= 1'b0;
      hold          <= '0;
    end else begin
      if (accept) begin
        icb_rsp_valid <= 1'b1;
        icb_rsp_err   <= !aligned;
        rsp_rd        <= icb_cmd_read && aligned;
        rsp_first     <= 1'b1;
      end else begin
        rsp_first <= 1'b0;
        if (icb_rsp_valid && icb_rsp_ready) begin
          icb_rsp_valid <= 1'b0;
          icb_rsp_err   <= 1'b0;
          rsp_rd        <= 1'b0;
        end
      end
      if (icb_rsp_valid && rsp_first && rsp_rd) hold <= ram_dout;
    end
  end

  assign icb_rsp_rdata = (icb_rsp_valid && rsp_rd) ? (rsp_first ? ram_dout : hold) : '0;

endmodule

// File: tb/tb_e203_dtcm_ram_ctrl.sv
// Directed bench for e203_dtcm_ram_ctrl: table of single transactions plus hand-written
// sequences for back-pressure, streaming, light sleep, deep sleep/shutdown and reset.
module tb_e203_dtcm_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic [15:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;
  logic        pwr_ds_req;
  logic        pwr_sd_req;
  logic        ram_sd, ram_ds, ram_ls, ram_cs, ram_we;
  logic [13:0] ram_addr;
  logic [3:0]  ram_wem;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        ctrl_idle;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  e203_dtcm_ram_ctrl #(.AW(14), .DW(32), .MW(4), .IDLE_LS_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
    .pwr_ds_req(pwr_ds_req), .pwr_sd_req(pwr_sd_req),
    .ram_sd(ram_sd), .ram_ds(ram_ds), .ram_ls(ram_ls),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wem(ram_wem), .ram_din(ram_din), .ram_dout(ram_dout),
    .ctrl_idle(ctrl_idle)
  );

  // RAM model: 1-cycle read latency; dout is garbage in cycles without a read.
  logic [31:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | i;
  always @(posedge clk) begin
    if (ram_cs && !ram_we) ram_dout <= mem[ram_addr[7:0]];
    else                   ram_dout <= 32'h0BADF00D;
    if (ram_cs && ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_wem[b]) mem[ram_addr[7:0]][b*8 +: 8] <= ram_din[b*8 +: 8];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_cmd(input logic v, input logic [15:0] a, input logic rd,
                           input logic [31:0] wd, input logic [3:0] wm);
    icb_cmd_valid = v;
    icb_cmd_addr  = a;
    icb_cmd_read  = rd;
    icb_cmd_wdata = wd;
    icb_cmd_wmask = wm;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        read;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        exp_cs;
    logic        exp_we;
    logic [13:0] exp_addr;
    logic [3:0]  exp_wem;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{16'h0010, 1'b0, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 14'h0004, 4'hF, 1'b0, 32'h0};
    vecs[1] = '{16'h0010, 1'b1, 32'h0,        4'h0, 1'b1, 1'b0, 14'h0004, 4'h0, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{16'h0014, 1'b0, 32'h11223344, 4'h5, 1'b1, 1'b1, 14'h0005, 4'h5, 1'b0, 32'h0};
    vecs[3] = '{16'h0014, 1'b1, 32'h0,        4'hF, 1'b1, 1'b0, 14'h0005, 4'h0, 1'b0, 32'hC0220044};
    vecs[4] = '{16'h0013, 1'b1, 32'h0,        4'h0, 1'b0, 1'b0, 14'h0004, 4'h0, 1'b1, 32'h0};
    vecs[5] = '{16'h0002, 1'b0, 32'h12345678, 4'hF, 1'b0, 1'b0, 14'h0000, 4'h0, 1'b1, 32'h0};
    vecs[6] = '{16'hFFFC, 1'b1, 32'h0,        4'h0, 1'b1, 1'b0, 14'h3FFF, 4'h0, 1'b0, 32'hC0DE00FF};

    rst_n = 1'b0;
    drive_cmd(1'b1, 16'h0000, 1'b1, 32'h0, 4'h0);
    icb_rsp_ready = 1'b1;
    pwr_ds_req = 1'b0;
    pwr_sd_req = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst cmd_ready", icb_cmd_ready, 0);
    check("rst ram_cs", ram_cs, 0);
    check("rst rsp_valid", icb_rsp_valid, 0);
    check("rst ram_ls", ram_ls, 0);
    check("rst ram_ds", ram_ds, 0);
    check("rst ram_sd", ram_sd, 0);
    check("rst ctrl_idle", ctrl_idle, 1);

    next_cycle();
    rst_n = 1'b1;
    icb_cmd_valid = 1'b0;

    // Single transactions from the table
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      drive_cmd(1'b1, vecs[i].addr, vecs[i].read, vecs[i].wdata, vecs[i].wmask);
      @(negedge clk);
      check($sformatf("v%0d cmd_ready", i), icb_cmd_ready, 1);
      check($sformatf("v%0d ram_cs", i), ram_cs, vecs[i].exp_cs);
      check($sformatf("v%0d ram_we", i), ram_we, vecs[i].exp_we);
      check($sformatf("v%0d ram_addr", i), ram_addr, vecs[i].exp_addr);
      check($sformatf("v%0d ram_wem", i), ram_wem, vecs[i].exp_wem);
      check($sformatf("v%0d ram_din", i), ram_din, vecs[i].wdata);
      next_cycle();
      icb_cmd_valid = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d rsp_valid", i), icb_rsp_valid, 1);
      check($sformatf("v%0d rsp_err", i), icb_rsp_err, vecs[i].exp_err);
      check($sformatf("v%0d rsp_rdata", i), icb_rsp_rdata, vecs[i].exp_rdata);
    end

    // Back-pressure: read held for 4 cycles while a second read waits
    next_cycle();
    drive_cmd(1'b1, 16'h0010, 1'b1, 32'h0, 4'h0);
    icb_rsp_ready = 1'b0;
    @(negedge clk);
    check("bp accept", icb_cmd_ready, 1);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      drive_cmd(1'b1, 16'h0000, 1'b1, 32'h0, 4'h0);
      @(negedge clk);
      check($sformatf("bp%0d rsp_valid", k), icb_rsp_valid, 1);
      check($sformatf("bp%0d rdata", k), icb_rsp_rdata, 32'hDEADBEEF);
      check($sformatf("bp%0d cmd_ready", k), icb_cmd_ready, 0);
      check($sformatf("bp%0d ram_cs", k), ram_cs, 0);
    end
    next_cycle();
    icb_rsp_ready = 1'b1;
    @(negedge clk);
    check("bp3 rdata", icb_rsp_rdata, 32'hDEADBEEF);
    check("bp3 cmd_ready", icb_cmd_ready, 1);
    check("bp3 ram_cs", ram_cs, 1);
    next_cycle();
    icb_cmd_valid = 1'b0;
    @(negedge clk);
    check("bp next rdata", icb_rsp_rdata, 32'hC0DE0000);

    // Streaming reads 0x0, 0x4, 0x8
    for (int j = 0; j < 4; j++) begin
      next_cycle();
      drive_cmd(j < 3, 16'(j * 4), 1'b1, 32'h0, 4'h0);
      @(negedge clk);
      if (j < 3) begin
        check($sformatf("bb%0d cmd_ready", j), icb_cmd_ready, 1);
        check($sformatf("bb%0d ram_addr", j), ram_addr, 14'(j));
      end
      if (j > 0) begin
        check($sformatf("bb%0d rsp_valid", j), icb_rsp_valid, 1);
        check($sformatf("bb%0d rdata", j), icb_rsp_rdata, 32'hC0DE0000 + 32'(j - 1));
      end
    end

    // Light sleep after 8 idle cycles, then wake on a command
    for (int n = 1; n <= 9; n++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("idle%0d ram_ls", n), ram_ls, 0);
    end
    next_cycle();
    @(negedge clk);
    check("ls ram_ls", ram_ls, 1);
    check("ls ctrl_idle", ctrl_idle, 0);
    check("ls cmd_ready", icb_cmd_ready, 0);
    next_cycle();
    drive_cmd(1'b1, 16'h0004, 1'b1, 32'h0, 4'h0);
    @(negedge clk);
    check("ls cmd ram_cs", ram_cs, 0);
    check("ls cmd ram_ls", ram_ls, 1);
    next_cycle();
    @(negedge clk);
    check("wake ram_ls", ram_ls, 0);
    check("wake cmd_ready", icb_cmd_ready, 0);
    check("wake ram_cs", ram_cs, 0);
    next_cycle();
    @(negedge clk);
    check("post-wake cmd_ready", icb_cmd_ready, 1);
    check("post-wake ram_cs", ram_cs, 1);
    next_cycle();
    icb_cmd_valid = 1'b0;
    @(negedge clk);
    check("post-wake rdata", icb_rsp_rdata, 32'hC0DE0001);

    // Shutdown/deep-sleep requests wait for the pending response
    next_cycle();
    drive_cmd(1'b1, 16'h0008, 1'b1, 32'h0, 4'h0);
    @(negedge clk);
    check("pw accept", icb_cmd_ready, 1);
    next_cycle();
    icb_cmd_valid = 1'b0;
    icb_rsp_ready = 1'b0;
    pwr_sd_req = 1'b1;
    pwr_ds_req = 1'b1;
    @(negedge clk);
    check("pw1 rdata", icb_rsp_rdata, 32'hC0DE0002);
    check("pw1 ram_sd", ram_sd, 0);
    next_cycle();
    @(negedge clk);
    check("pw2 ram_sd", ram_sd, 0);
    check("pw2 ctrl_idle", ctrl_idle, 0);
    next_cycle();
    icb_rsp_ready = 1'b1;
    @(negedge clk);
    check("pw3 rsp_valid", icb_rsp_valid, 1);
    check("pw3 ram_sd", ram_sd, 0);
    next_cycle();
    @(negedge clk);
    check("pw4 rsp_valid", icb_rsp_valid, 0);
    check("pw4 ram_sd", ram_sd, 0);
    check("pw4 ctrl_idle", ctrl_idle, 1);
    next_cycle();
    @(negedge clk);
    check("sd ram_sd", ram_sd, 1);
    check("sd ram_ds", ram_ds, 0);
    check("sd ram_ls", ram_ls, 0);
    check("sd cmd_ready", icb_cmd_ready, 0);
    next_cycle();
    pwr_sd_req = 1'b0;
    @(negedge clk);
    check("sd exit ram_sd", ram_sd, 1);
    next_cycle();
    @(negedge clk);
    check("ds ram_ds", ram_ds, 1);
    check("ds ram_sd", ram_sd, 0);
    next_cycle();
    pwr_ds_req = 1'b0;
    @(negedge clk);
    check("ds exit ram_ds", ram_ds, 1);
    next_cycle();
    @(negedge clk);
    check("wake2 ram_ds", ram_ds, 0);
    check("wake2 ram_sd", ram_sd, 0);
    check("wake2 cmd_ready", icb_cmd_ready, 0);
    check("wake2 ctrl_idle", ctrl_idle, 0);
    next_cycle();
    @(negedge clk);
    check("active ctrl_idle", ctrl_idle, 1);
    check("active cmd_ready", icb_cmd_ready, 1);

    // Reset in the middle of a pending response
    next_cycle();
    drive_cmd(1'b1, 16'h0000, 1'b1, 32'h0, 4'h0);
    icb_rsp_ready = 1'b0;
    @(negedge clk);
    check("mr accept", icb_cmd_ready, 1);
    next_cycle();
    icb_cmd_valid = 1'b0;
    @(negedge clk);
    check("mr rsp_valid", icb_rsp_valid, 1);
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    check("mr cmd_ready in rst", icb_cmd_ready, 0);
    next_cycle();
    @(negedge clk);
    check("mr rsp_valid dropped", icb_rsp_valid, 0);
    check("mr rdata", icb_rsp_rdata, 0);
    check("mr err", icb_rsp_err, 0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("mr cmd_ready after", icb_cmd_ready, 1);
    check("mr ctrl_idle after", ctrl_idle, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
